bitty_exec_unit: RTL

//  Parametrised multi-cycle execute engine for the bitty core: 2**REG_AW x DATA_W register file, S/C staging regs, 74181-style ALU.

---
 rtl/bitty_exec_unit.sv | 227 ++++++++++++++++++++++
 1 files changed

// File: rtl/bitty_exec_unit.sv
// ============================================================================
// bitty_exec_unit
// ----------------------------------------------------------------------------
// Multi-cycle execute engine for the bitty core. It holds a 2**REG_AW x DATA_W
// register file, the S (operand A) and C (result) staging registers, and a
// 74181-style ALU. One instruction is accepted per run/busy/done handshake.
// The result is written back to register Rx.
//
// Instruction layout, MSB to LSB:
//   {rx[REG_AW], ry[REG_AW], rsvd[2:0], sel[3:0], mode, fmt[1:0]}
//
// Ports:
//   i_clk        single clock; all state changes on the rising edge
//   i_rst_n      asynchronous active-low reset
//   i_run        start request; sampled only while idle
//   i_instr      instruction word, captured together with i_run
//   o_busy       high from the accept edge until the writeback edge
//   o_done       one-cycle pulse after the writeback edge
//   o_carry      ALU carry of the last executed legal instruction
//   o_compare    (S == B) of the last executed legal instruction
//   o_illegal    the last instruction had an unsupported format
//   i_dbg_addr   debug register select
//   o_dbg_data   combinational read of reg[i_dbg_addr]
//
// Build option:
//   BITTY_IMM_EN  when defined, fmt 01 selects immediate mode, where
//                 B = zero-extended {ry, rsvd}. When undefined, fmt 01 is
//                 treated as illegal and no immediate mux is built.
// ============================================================================
module bitty_exec_unit #(
    parameter  int DATA_W  = 16,
    parameter  int REG_AW  = 3,
    localparam int INSTR_W = 2*REG_AW + 10
) (
    input  logic               i_clk,
    input  logic               i_rst_n,
    input  logic               i_run,
    input  logic [INSTR_W-1:0] i_instr,
    output logic               o_busy,
    output logic               o_done,
    output logic               o_carry,
    output logic               o_compare,
    output logic               o_illegal,
    input  logic [REG_AW-1:0]  i_dbg_addr,
    output logic [DATA_W-1:0]  o_dbg_data
);

    localparam int NUM_REGS = 1 << REG_AW;
    localparam logic [DATA_W-1:0] ONE = DATA_W'(1);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_LOAD_S,
        ST_EXEC,
        ST_WB
    } state_t;

    state_t              r_state;
    logic [INSTR_W-1:0]  r_ir;
    logic [DATA_W-1:0]   r_regs [NUM_REGS];
    logic [DATA_W-1:0]   r_s;
    logic [DATA_W-1:0]   r_c;
    logic                r_busy;
    logic                r_done;
    logic                r_carry;
    logic                r_compare;
    logic                r_illegal;

    logic [REG_AW-1:0]   w_rx;
    logic [REG_AW-1:0]   w_ry;
    logic [2:0]          w_rsvd;
    logic [3:0]          w_sel;
    logic                w_mode;
    logic [1:0]          w_fmt;
    logic                w_legal;
    logic [DATA_W-1:0]   w_b;

    logic [DATA_W-1:0]   w_addX;
    logic [DATA_W-1:0]   w_addY;
    logic                w_useSum;
    logic [DATA_W-1:0]   w_aluRes;
    logic [DATA_W:0]     w_sum;
    logic [DATA_W-1:0]   w_result;
    logic                w_carryOut;

    // All fields are decoded from the latched IR. This keeps the sequencer
    // free to change i_instr while an instruction is in flight.
    assign w_rx   = r_ir[INSTR_W-1 -: REG_AW];
    assign w_ry   = r_ir[INSTR_W-REG_AW-1 -: REG_AW];
    assign w_rsvd = r_ir[9:7];
    assign w_sel  = r_ir[6:3];
    assign w_mode = r_ir[2];
    assign w_fmt  = r_ir[1:0];

`ifdef BITTY_IMM_EN
    // The immediate is {ry, rsvd}. It is widened before truncation so that
    // narrow DATA_W builds still elaborate cleanly.
    logic [DATA_W+REG_AW+2:0] w_immWide;
    assign w_immWide = {{DATA_W{1'b0}}, w_ry, w_rsvd};
    assign w_legal   = (w_fmt == 2'b00) || (w_fmt == 2'b01);
    assign w_b       = (w_fmt == 2'b01) ? w_immWide[DATA_W-1:0] : r_regs[w_ry];
`else
    // The reserved bits only carry meaning in immediate builds.
    logic w_unusedRsvd;
    assign w_unusedRsvd = ^w_rsvd;
    assign w_legal      = (w_fmt == 2'b00);
    assign w_b          = r_regs[w_ry];
`endif

    // 74181 function table with carry-in 0, using active-high data.
    // Forms that add two operands go through one shared DATA_W+1 adder,
    // so the carry is that adder's top bit. Decrement and subtract forms
    // wrap, and their carry reads as 0.
    always_comb begin
        w_addX   = '0;
        w_addY   = '0;
        w_useSum = 1'b0;
        w_aluRes = '0;
        if (w_mode) begin
            case (w_sel)
                4'b0000: w_aluRes = ~r_s;
                4'b0001: w_aluRes = ~(r_s | w_b);
                4'b0010: w_aluRes = ~r_s & w_b;
                4'b0011: w_aluRes = '0;
                4'b0100: w_aluRes = ~(r_s & w_b);
                4'b0101: w_aluRes = ~w_b;
                4'b0110: w_aluRes = r_s ^ w_b;
                4'b0111: w_aluRes = r_s & ~w_b;
                4'b1000: w_aluRes = ~r_s | w_b;
                4'b1001: w_aluRes = ~(r_s ^ w_b);
                4'b1010: w_aluRes = w_b;
                4'b1011: w_aluRes = r_s & w_b;
                4'b1100: w_aluRes = '1;
                4'b1101: w_aluRes = r_s | ~w_b;
                4'b1110: w_aluRes = r_s | w_b;
                default: w_aluRes = r_s;
            endcase
        end else begin
            case (w_sel)
                4'b0000: w_aluRes = r_s;
                4'b0001: w_aluRes = r_s | w_b;
                4'b0010: w_aluRes = r_s | ~w_b;
                4'b0011: w_aluRes = '1;
                4'b0100: begin w_useSum = 1'b1; w_addX = r_s;         w_addY = r_s & ~w_b; end
                4'b0101: begin w_useSum = 1'b1; w_addX = r_s | w_b;   w_addY = r_s & ~w_b; end
                4'b0110: w_aluRes = r_s - w_b - ONE;
                4'b0111: w_aluRes = (r_s & ~w_b) - ONE;
                4'b1000: begin w_useSum = 1'b1; w_addX = r_s;         w_addY = r_s & w_b;  end
                4'b1001: begin w_useSum = 1'b1; w_addX = r_s;         w_addY = w_b;        end
                4'b1010: begin w_useSum = 1'b1; w_addX = r_s | ~w_b;  w_addY = r_s & w_b;  end
                4'b1011: w_aluRes = (r_s & w_b) - ONE;
                4'b1100: begin w_useSum = 1'b1; w_addX = r_s;         w_addY = r_s;        end
                4'b1101: begin w_useSum = 1'b1; w_addX = r_s | w_b;   w_addY = r_s;        end
                4'b1110: begin w_useSum = 1'b1; w_addX = r_s | ~w_b;  w_addY = r_s;        end
                default: w_aluRes = r_s - ONE;
            endcase
        end
    end

    assign w_sum      = {1'b0, w_addX} + {1'b0, w_addY};
    assign w_result   = w_useSum ? w_sum[DATA_W-1:0] : w_aluRes;
    assign w_carryOut = w_useSum & w_sum[DATA_W];

    // Sequencer, datapath registers and register file in one block.
    // Reset aborts any instruction in flight: nothing is written back and
    // o_done does not pulse.
    // An illegal instruction still takes the full four-cycle path. This
    // keeps the handshake timing identical for every instruction.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state   <= ST_IDLE;
            r_ir      <= '0;
            r_s       <= '0;
            r_c       <= '0;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
            r_carry   <= 1'b0;
            r_compare <= 1'b0;
            r_illegal <= 1'b0;
            for (int i = 0; i < NUM_REGS; i++) begin
                r_regs[i] <= '0;
            end
        end else begin
            r_done <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (i_run) begin
                        r_ir    <= i_instr;
                        r_busy  <= 1'b1;
                        r_state <= ST_LOAD_S;
                    end
                end
                ST_LOAD_S: begin
                    r_s     <= r_regs[w_rx];
                    r_state <= ST_EXEC;
                end
                ST_EXEC: begin
                    if (w_legal) begin
                        r_c       <= w_result;
                        r_carry   <= w_carryOut;
                        r_compare <= (r_s == w_b);
                        r_illegal <= 1'b0;
                    end else begin
                        r_illegal <= 1'b1;
                    end
                    r_state <= ST_WB;
                end
                default: begin
                    if (w_legal) begin
                        r_regs[w_rx] <= r_c;
                    end
                    r_busy  <= 1'b0;
                    r_done  <= 1'b1;
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign o_busy     = r_busy;
    assign o_done     = r_done;
    assign o_carry    = r_carry;
    assign o_compare  = r_compare;
    assign o_illegal  = r_illegal;
    assign o_dbg_data = r_regs[i_dbg_addr];

endmodule
